// File: rtl/dead_time_bridge_driver.sv
// -----------------------------------------------------------------------------
// dead_time_bridge_driver
//
// Purpose: turns the raw 4-bit full-bridge MOSFET command into registered gate
// drive. Each leg gets a programmable dead time between transitions, a minimum
// on-time once a gate is asserted, and shoot-through blocking. An illegal
// command (both switches of a leg requested) latches a sticky fault that keeps
// every gate off until it is cleared.
//
// Leg mapping: A = {gate[0] high-side, gate[2] low-side}
//              B = {gate[1] high-side, gate[3] low-side}
//
// Ports:
//   i_clock      in   1  system clock, rising edge
//   i_RESET      in   1  synchronous, active-high reset
//   i_enable     in   1  0 = all gates off, legs idle; 1 = follow i_MOSFET
//   i_fault_clr  in   1  synchronous clear of the sticky fault
//   i_MOSFET     in   4  raw command (same bit mapping as o_gate)
//   o_gate       out  4  registered gate drive
//   o_dead       out  2  [0] = leg A, [1] = leg B in dead interval
//   o_fault      out  1  sticky fault: illegal command seen
//
// Timing: i_MOSFET is captured in req_q, the leg FSMs act on req_q, and the
// gate/dead outputs are a registered decode of the FSM state. A command seen
// at edge k therefore drops the conducting gate at k+2 and raises the opposite
// gate at k+2+DEAD_TIME. Fault, disable and reset bypass that decode stage and
// zero the outputs at the very edge they are sampled.
// -----------------------------------------------------------------------------
module dead_time_bridge_driver #(
  parameter int DEAD_TIME = 50,
  parameter int MIN_ON    = 125,
  parameter int CNT_W     = 16
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       i_enable,
  input  logic       i_fault_clr,
  input  logic [3:0] i_MOSFET,
  output logic [3:0] o_gate,
  output logic [1:0] o_dead,
  output logic       o_fault
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ON_HI = 2'd1;
  localparam logic [1:0] ST_ON_LO = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_TIME);
  localparam logic [CNT_W-1:0] MIN_LOAD  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Per-leg FSM state and its counter, kept together so a checker can bind to
  // leg_q[0] / leg_q[1] directly.
  typedef struct packed {
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
  } leg_t;

  logic [3:0] req_q;
  logic [1:0] req_hi;
  logic [1:0] req_lo;
  logic       illegal;
  logic       block;
  leg_t       leg_q [2];
  leg_t       leg_d [2];
  logic [3:0] gate_d;
  logic [1:0] dead_d;

  assign req_hi  = req_q[1:0];
  assign req_lo  = req_q[3:2];
  assign illegal = |(req_hi & req_lo);
  // Anything that must force both legs to IDLE at this edge.
  assign block   = illegal | o_fault | ~i_enable;

  always_comb begin
    gate_d = '0;
    dead_d = '0;
    for (int i = 0; i < 2; i++) begin
      leg_d[i]    = leg_q[i];
      gate_d[i]   = (leg_q[i].state == ST_ON_HI);
      gate_d[i+2] = (leg_q[i].state == ST_ON_LO);
      dead_d[i]   = (leg_q[i].state == ST_DEAD);

      if (block) begin
        leg_d[i].state = ST_IDLE;
        leg_d[i].cnt   = '0;
      end else begin
        case (leg_q[i].state)
          ST_IDLE: begin
            leg_d[i].cnt = '0;
            // Start-up always passes through a full dead interval.
            if (req_hi[i] ^ req_lo[i]) begin
              leg_d[i].state = ST_DEAD;
              leg_d[i].cnt   = DEAD_LOAD;
            end
          end
          ST_DEAD: begin
            // Leave on the cycle the counter reads 1, using the request
            // present now; reversals earlier in the interval are ignored.
            if (leg_q[i].cnt > CNT_ONE) begin
              leg_d[i].cnt = leg_q[i].cnt - CNT_ONE;
            end else if (req_hi[i]) begin
              leg_d[i].state = ST_ON_HI;
              leg_d[i].cnt   = MIN_LOAD;
            end else if (req_lo[i]) begin
              leg_d[i].state = ST_ON_LO;
              leg_d[i].cnt   = MIN_LOAD;
            end else begin
              leg_d[i].state = ST_IDLE;
              leg_d[i].cnt   = '0;
            end
          end
          ST_ON_HI: begin
            // Requests during min-on are not queued; only the level at
            // expiry (counter at 1 or 0) decides.
            if (leg_q[i].cnt > CNT_ONE) begin
              leg_d[i].cnt = leg_q[i].cnt - CNT_ONE;
            end else if (req_hi[i] && !req_lo[i]) begin
              leg_d[i].cnt = (leg_q[i].cnt == '0) ? '0 : leg_q[i].cnt - CNT_ONE;
            end else begin
              leg_d[i].state = ST_DEAD;
              leg_d[i].cnt   = DEAD_LOAD;
            end
          end
          ST_ON_LO: begin
            if (leg_q[i].cnt > CNT_ONE) begin
              leg_d[i].cnt = leg_q[i].cnt - CNT_ONE;
            end else if (req_lo[i] && !req_hi[i]) begin
              leg_d[i].cnt = (leg_q[i].cnt == '0) ? '0 : leg_q[i].cnt - CNT_ONE;
            end else begin
              leg_d[i].state = ST_DEAD;
              leg_d[i].cnt   = DEAD_LOAD;
            end
          end
          default: begin
            leg_d[i].state = ST_IDLE;
            leg_d[i].cnt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      req_q   <= '0;
      o_gate  <= '0;
      o_dead  <= '0;
      o_fault <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        leg_q[i] <= '0;
      end
    end else begin
      req_q <= i_MOSFET;
      for (int i = 0; i < 2; i++) begin
        leg_q[i] <= leg_d[i];
      end
      // Set wins over clear when the illegal command is still present.
      o_fault <= illegal | (o_fault & ~i_fault_clr);
      if (block) begin
        o_gate <= '0;
        o_dead <= '0;
      end else begin
        o_gate <= gate_d;
        o_dead <= dead_d;
      end
    end
  end

endmodule

// File: tb/tb_dead_time_bridge_driver.sv
// -----------------------------------------------------------------------------
// tb_dead_time_bridge_driver
//
// Bench for dead_time_bridge_driver with DEAD_TIME=50, MIN_ON=125.
// Each stimulus record holds its inputs for `dwell` edges and predicts the
// outputs seen after the last of those edges; that prediction goes into
// exp_q when the record is driven and is popped by the monitor at the
// matching cycle. A random legal-command phase then checks pulse widths,
// in-leg gaps and the shoot-through invariant.
// -----------------------------------------------------------------------------
module tb_dead_time_bridge_driver;

  localparam int DEAD_TIME = 50;
  localparam int MIN_ON    = 125;
  localparam int W         = 55;  // {id[15:0], cycle[31:0], gate[3:0], dead[1:0], fault}

  // ---------------- clock / reset ----------------
  logic       i_clock = 1'b0;
  logic       i_RESET;
  logic       i_enable;
  logic       i_fault_clr;
  logic [3:0] i_MOSFET;
  logic [3:0] o_gate;
  logic [1:0] o_dead;
  logic       o_fault;

  always #2 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  dead_time_bridge_driver #(
    .DEAD_TIME (DEAD_TIME),
    .MIN_ON    (MIN_ON),
    .CNT_W     (16)
  ) dut (
    .i_clock     (i_clock),
    .i_RESET     (i_RESET),
    .i_enable    (i_enable),
    .i_fault_clr (i_fault_clr),
    .i_MOSFET    (i_MOSFET),
    .o_gate      (o_gate),
    .o_dead      (o_dead),
    .o_fault     (o_fault)
  );

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_errors = 0;
  logic [W-1:0]   exp_q[$];
  bit             chk_en = 1'b0;
  logic [3:0]     prev_gate = '0;
  int             rise_cyc [4];
  int             last_fall [2];

  typedef struct {
    logic       rst;
    logic [3:0] m;
    logic       en;
    logic       clr;
    int         dwell;
    logic [3:0] g;
    logic [1:0] d;
    logic       f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] m, input logic en,
                              input logic clr, input int dwell, input logic [3:0] g,
                              input logic [1:0] d, input logic f);
    vec_t v;
    v.rst = rst; v.m = m; v.en = en; v.clr = clr; v.dwell = dwell;
    v.g = g; v.d = d; v.f = f;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input vec_t v, input int id);
    i_RESET     = v.rst;
    i_MOSFET    = v.m;
    i_enable    = v.en;
    i_fault_clr = v.clr;
    exp_q.push_back({16'(id), 32'(cyc + v.dwell), v.g, v.d, v.f});
    repeat (v.dwell) @(negedge i_clock);
  endtask

  task automatic check(input string name, input int at, input logic [6:0] got,
                       input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got gate/dead/fault=%b required %b", name, at, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clock) begin
    logic [W-1:0] e;
    n_checks++;
    if (((o_gate[0] & o_gate[2]) | (o_gate[1] & o_gate[3])) !== 1'b0) begin
      n_errors++;
      $display("FAIL shoot_through at cycle %0d: got gate=%b required no leg with both on", cyc, o_gate);
    end

    while (exp_q.size() > 0 && int'(exp_q[0][38:7]) <= cyc) begin
      e = exp_q.pop_front();
      if (int'(e[38:7]) < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL row%0d: expectation for cycle %0d missed (now %0d)", e[54:39], e[38:7], cyc);
      end else begin
        check($sformatf("row%0d", e[54:39]), cyc, {o_gate, o_dead, o_fault}, e[6:0]);
      end
    end

    if (chk_en) begin
      n_checks++;
      if (o_fault !== 1'b0) begin
        n_errors++;
        $display("FAIL random_fault at cycle %0d: got fault=%b required 0", cyc, o_fault);
      end
      for (int g = 0; g < 4; g++) begin
        if (o_gate[g] && !prev_gate[g]) begin
          n_checks++;
          if (cyc - last_fall[g % 2] < DEAD_TIME) begin
            n_errors++;
            $display("FAIL dead_gap gate%0d at cycle %0d: got gap %0d required >= %0d",
                     g, cyc, cyc - last_fall[g % 2], DEAD_TIME);
          end
          rise_cyc[g] = cyc;
        end else if (!o_gate[g] && prev_gate[g]) begin
          n_checks++;
          if (cyc - rise_cyc[g] < MIN_ON) begin
            n_errors++;
            $display("FAIL min_on gate%0d at cycle %0d: got width %0d required >= %0d",
                     g, cyc, cyc - rise_cyc[g], MIN_ON);
          end
          last_fall[g % 2] = cyc;
        end
      end
    end
    prev_gate = o_gate;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] e;
    int total;
    int hold;
    int la;
    int lb;

    i_RESET = 1'b1; i_enable = 1'b0; i_fault_clr = 1'b0; i_MOSFET = 4'b0000;

    // rst, cmd, en, clr, dwell -> gate, dead, fault (observed after the dwell)
    tbl.push_back(mk(1, 4'b0000, 0, 0,   3, 4'b0000, 2'b00, 0)); // reset state
    // start-up: 1001 -> gates rise 52 edges after capture, dead=11 meanwhile
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,  49, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0, 198, 4'b1001, 2'b00, 0));
    // steady-state reversal: fall 2 edges after capture, rise 50 later
    tbl.push_back(mk(0, 4'b0110, 1, 0,   1, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(0, 4'b0110, 1, 0,   1, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(0, 4'b0110, 1, 0,   1, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(0, 4'b0110, 1, 0,  49, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(0, 4'b0110, 1, 0,   1, 4'b0110, 2'b00, 0));
    // reversal 10 cycles into min-on: gate held for exactly 125 cycles
    tbl.push_back(mk(0, 4'b1001, 1, 0,  10, 4'b0110, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0, 114, 4'b0110, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,  49, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b1001, 2'b00, 0));
    // 5-cycle glitch inside min-on is ignored
    tbl.push_back(mk(0, 4'b0110, 1, 0,   5, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0, 150, 4'b1001, 2'b00, 0));
    // one-cycle illegal on leg A -> sticky fault, gates off
    tbl.push_back(mk(0, 4'b0101, 1, 0,   1, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b0000, 2'b00, 1));
    tbl.push_back(mk(0, 4'b1001, 1, 0, 100, 4'b0000, 2'b00, 1));
    tbl.push_back(mk(0, 4'b1001, 1, 1,   1, 4'b0000, 2'b00, 0)); // clear
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,  49, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 0,   1, 4'b1001, 2'b00, 0));
    // clear while illegal still present: set wins
    tbl.push_back(mk(0, 4'b1111, 1, 0,   1, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 1,   1, 4'b0000, 2'b00, 1));
    tbl.push_back(mk(0, 4'b1111, 1, 1,   3, 4'b0000, 2'b00, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1,   1, 4'b0000, 2'b00, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1,   1, 4'b0000, 2'b00, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0,   5, 4'b0000, 2'b00, 0));

    @(negedge i_clock);
    foreach (tbl[i]) apply(tbl[i], i);

    // enable dropped mid-dead, then re-enable: full dead interval
    apply(mk(0, 4'b1001, 1, 0, 21, 4'b0000, 2'b11, 0), 100);
    apply(mk(0, 4'b1001, 0, 0,  1, 4'b0000, 2'b00, 0), 101);
    apply(mk(0, 4'b1001, 0, 0, 10, 4'b0000, 2'b00, 0), 102);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b0000, 2'b00, 0), 103);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b0000, 2'b11, 0), 104);
    apply(mk(0, 4'b1001, 1, 0, 49, 4'b0000, 2'b11, 0), 105);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b1001, 2'b00, 0), 106);
    // enable dropped mid-on
    apply(mk(0, 4'b1001, 1, 0, 20, 4'b1001, 2'b00, 0), 107);
    apply(mk(0, 4'b1001, 0, 0,  1, 4'b0000, 2'b00, 0), 108);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b0000, 2'b00, 0), 109);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b0000, 2'b11, 0), 110);
    apply(mk(0, 4'b1001, 1, 0, 49, 4'b0000, 2'b11, 0), 111);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b1001, 2'b00, 0), 112);
    // reset mid-min-on, then restart through a dead interval
    apply(mk(0, 4'b1001, 1, 0, 30, 4'b1001, 2'b00, 0), 113);
    apply(mk(1, 4'b1001, 1, 0,  1, 4'b0000, 2'b00, 0), 114);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b0000, 2'b00, 0), 115);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b0000, 2'b00, 0), 116);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b0000, 2'b11, 0), 117);
    apply(mk(0, 4'b1001, 1, 0, 49, 4'b0000, 2'b11, 0), 118);
    apply(mk(0, 4'b1001, 1, 0,  1, 4'b1001, 2'b00, 0), 119);

    // random legal command stream
    apply(mk(1, 4'b0000, 0, 0, 2, 4'b0000, 2'b00, 0), 200);
    apply(mk(0, 4'b0000, 1, 0, 1, 4'b0000, 2'b00, 0), 201);
    last_fall[0] = cyc;
    last_fall[1] = cyc;
    for (int g = 0; g < 4; g++) rise_cyc[g] = cyc;
    chk_en = 1'b1;
    total = 0;
    while (total < 20000) begin
      la = $urandom_range(0, 2);  // 0 off, 1 high, 2 low
      lb = $urandom_range(0, 2);
      i_MOSFET = {lb == 2, la == 2, lb == 1, la == 1};
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(20, 300);
      repeat (hold) @(negedge i_clock);
      total += hold;
    end
    i_MOSFET = 4'b0000;
    repeat (400) @(negedge i_clock);
    chk_en = 1'b0;
    apply(mk(0, 4'b0000, 1, 0, 1, 4'b0000, 2'b00, 0), 202);
    repeat (3) @(negedge i_clock);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL row%0d: expectation for cycle %0d never checked", e[54:39], e[38:7]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
